// File: rtl/pipe_pkg.sv
// Shared definitions for the ID->EXE pipeline stage: control-bit layout,
// default field widths and the skid buffer state encoding.
package pipe_pkg;

  // Control vector, MSB first: {regWr, memRd, memWr, cWr, zWr}
  localparam int CTRL_W = 5;
  localparam int REGWR  = 4;
  localparam int MEMRD  = 3;
  localparam int MEMWR  = 2;
  localparam int CWR    = 1;
  localparam int ZWR    = 0;

  // Default datapath widths
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_PC_W    = 12;
  localparam int DEF_RA_W    = 3;
  localparam int DEF_ALUOP_W = 4;

  // Occupancy of the two-entry skid buffer
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready stage register with synchronous flush. SKID!=0 gives a
// two-entry skid buffer whose in_ready is a register, so downstream
// back-pressure never reaches the producer combinationally. SKID==0 gives a
// single entry with pass-through ready.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int W    = 8,
  parameter int SKID = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] main_q;
  logic         valid_q;

  assign out_valid_o = valid_q;
  assign data_o      = main_q;

  if (SKID != 0) begin : g_skid
    skid_state_e  state_q;
    logic [W-1:0] skid_q;
    logic         ready_q;
    logic         accept;
    logic         deliver;

    assign in_ready_o = ready_q;
    assign accept     = in_valid_i & ready_q;
    assign deliver    = valid_q & out_ready_i;

    // Occupancy FSM; main entry feeds the outputs, skid entry absorbs the
    // one extra word that arrives while ready is still registered high.
    // NOTE: all state here is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_EMPTY;
        valid_q <= 1'b0;
        ready_q <= 1'b1;
        main_q  <= '0;
        skid_q  <= '0;
      end else if (flush_i) begin
        // NOTE: flush only drops the valid flags; payload registers keep
        // their contents because nothing downstream may use them unqualified.
        state_q <= ST_EMPTY;
        valid_q <= 1'b0;
        ready_q <= 1'b1;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (accept) begin
              main_q  <= data_i;
              valid_q <= 1'b1;
              state_q <= ST_ONE;
            end
          end
          ST_ONE: begin
            if (accept && deliver) begin
              main_q <= data_i;
            end else if (accept) begin
              skid_q  <= data_i;
              ready_q <= 1'b0;
              state_q <= ST_FULL;
            end else if (deliver) begin
              valid_q <= 1'b0;
              state_q <= ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (deliver) begin
              main_q  <= skid_q;
              ready_q <= 1'b1;
              state_q <= ST_ONE;
            end
          end
          default: begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end else begin : g_single
    logic accept;
    logic deliver;

    assign in_ready_o = ~valid_q | out_ready_i;
    assign accept     = in_valid_i & in_ready_o;
    assign deliver    = valid_q & out_ready_i;

    // Single entry: load on accept, go empty when drained with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        main_q  <= '0;
      end else if (flush_i) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        main_q  <= data_i;
        valid_q <= 1'b1;
      end else if (deliver) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/id_exe_pipe_stage.sv
// ID->EXE pipeline register: packs decode fields into one vector, runs it
// through the handshake buffer and masks control bits for bubbles.
module id_exe_pipe_stage #(
  parameter int DATA_W  = pipe_pkg::DEF_DATA_W,
  parameter int PC_W    = pipe_pkg::DEF_PC_W,
  parameter int RA_W    = pipe_pkg::DEF_RA_W,
  parameter int ALUOP_W = pipe_pkg::DEF_ALUOP_W,
  parameter int CTRL_W  = pipe_pkg::CTRL_W,
  parameter int SKID    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  input  logic [CTRL_W-1:0]  ctrl_in,
  input  logic [ALUOP_W-1:0] aluop_in,
  input  logic [RA_W-1:0]    rd_in,
  input  logic [RA_W-1:0]    rs_in,
  input  logic [RA_W-1:0]    rt_in,
  input  logic [DATA_W-1:0]  imm_in,
  input  logic [DATA_W-1:0]  rdata1_in,
  input  logic [DATA_W-1:0]  rdata2_in,
  input  logic [DATA_W-1:0]  brdisp_in,
  input  logic [PC_W-1:0]    pcp1_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  ctrl_out,
  output logic [ALUOP_W-1:0] aluop_out,
  output logic [RA_W-1:0]    rd_out,
  output logic [RA_W-1:0]    rs_out,
  output logic [RA_W-1:0]    rt_out,
  output logic [DATA_W-1:0]  imm_out,
  output logic [DATA_W-1:0]  rdata1_out,
  output logic [DATA_W-1:0]  rdata2_out,
  output logic [DATA_W-1:0]  brdisp_out,
  output logic [PC_W-1:0]    pcp1_out
);

  localparam int PAY_W = CTRL_W + ALUOP_W + 3 * RA_W + 4 * DATA_W + PC_W;

  logic [PAY_W-1:0]  pay_in;
  logic [PAY_W-1:0]  pay_out;
  logic [CTRL_W-1:0] ctrl_raw;

  assign pay_in = {ctrl_in, aluop_in, rd_in, rs_in, rt_in,
                   imm_in, rdata1_in, rdata2_in, brdisp_in, pcp1_in};

  pipe_skid_buf #(
    .W    (PAY_W),
    .SKID (SKID)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .data_i      (pay_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .data_o      (pay_out)
  );

  assign {ctrl_raw, aluop_out, rd_out, rs_out, rt_out,
          imm_out, rdata1_out, rdata2_out, brdisp_out, pcp1_out} = pay_out;

  // A bubble must never write the register file, memory or flags.
  assign ctrl_out = out_valid ? ctrl_raw : '0;

endmodule

// File: tb/tb_id_exe_pipe_stage.sv
// Bench for id_exe_pipe_stage: one SKID=1 and one SKID=0 instance share the
// stimulus; a queue model per instance predicts every output each cycle.
module tb_id_exe_pipe_stage;
  import pipe_pkg::*;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [3:0]  aluop;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [7:0]  imm;
    logic [7:0]  r1;
    logic [7:0]  r2;
    logic [7:0]  bd;
    logic [11:0] pc;
  } pay_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic out_ready = 1'b1;
  pay_t in_p = '0;

  logic ir1, ov1, ir0, ov0;
  pay_t o1, o0;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Reference model: contents in FIFO order, plus the value the main
  // register still shows once the stage is empty.
  pay_t q1[$];
  pay_t q0[$];
  pay_t last1 = '0;
  pay_t last0 = '0;

  always #5 clk = ~clk;

  id_exe_pipe_stage #(.SKID(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .flush(flush),
    .ctrl_in(in_p.ctrl), .aluop_in(in_p.aluop), .rd_in(in_p.rd), .rs_in(in_p.rs),
    .rt_in(in_p.rt), .imm_in(in_p.imm), .rdata1_in(in_p.r1), .rdata2_in(in_p.r2),
    .brdisp_in(in_p.bd), .pcp1_in(in_p.pc), .out_valid(ov1), .out_ready(out_ready),
    .ctrl_out(o1.ctrl), .aluop_out(o1.aluop), .rd_out(o1.rd), .rs_out(o1.rs),
    .rt_out(o1.rt), .imm_out(o1.imm), .rdata1_out(o1.r1), .rdata2_out(o1.r2),
    .brdisp_out(o1.bd), .pcp1_out(o1.pc)
  );

  id_exe_pipe_stage #(.SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .flush(flush),
    .ctrl_in(in_p.ctrl), .aluop_in(in_p.aluop), .rd_in(in_p.rd), .rs_in(in_p.rs),
    .rt_in(in_p.rt), .imm_in(in_p.imm), .rdata1_in(in_p.r1), .rdata2_in(in_p.r2),
    .brdisp_in(in_p.bd), .pcp1_in(in_p.pc), .out_valid(ov0), .out_ready(out_ready),
    .ctrl_out(o0.ctrl), .aluop_out(o0.aluop), .rd_out(o0.rd), .rs_out(o0.rs),
    .rt_out(o0.rt), .imm_out(o0.imm), .rdata1_out(o0.r1), .rdata2_out(o0.r2),
    .brdisp_out(o0.bd), .pcp1_out(o0.pc)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pay_t mk(input logic [7:0] n);
    pay_t p;
    p.ctrl  = n[4:0];
    p.aluop = n[7:4];
    p.rd    = n[2:0];
    p.rs    = n[5:3];
    p.rt    = n[7:5];
    p.imm   = n;
    p.r1    = n ^ 8'hFF;
    p.r2    = n + 8'd1;
    p.bd    = {n[3:0], n[7:4]};
    p.pc    = {4'hC, n};
    return p;
  endfunction

  // Advance the model one clock according to the handshake rules.
  function automatic void model_step(ref pay_t q[$], ref pay_t last, input bit skid);
    bit rdy, acc, del;
    rdy = skid ? (q.size() < 2) : (q.size() == 0 || out_ready);
    acc = in_valid && rdy && !flush;
    del = (q.size() > 0) && out_ready;
    if (flush) q.delete();
    else begin
      if (del) void'(q.pop_front());
      if (acc) q.push_back(in_p);
    end
    if (q.size() > 0) last = q[0];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(q1, last1, 1'b1);
    model_step(q0, last0, 1'b0);
    #1;
  endtask

  task automatic model_reset();
    q1.delete();
    q0.delete();
    last1 = '0;
    last0 = '0;
  endtask

  // Compare both instances with the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      pay_t e;
      check("s1_valid", 64'(ov1), 64'(q1.size() > 0));
      check("s1_ready", 64'(ir1), 64'(q1.size() < 2));
      e = (q1.size() > 0) ? q1[0] : last1;
      if (q1.size() == 0) e.ctrl = '0;
      check("s1_payload", 64'(o1), 64'(e));
      check("s0_valid", 64'(ov0), 64'(q0.size() > 0));
      check("s0_ready", 64'(ir0), 64'(q0.size() == 0 || out_ready));
      e = (q0.size() > 0) ? q0[0] : last0;
      if (q0.size() == 0) e.ctrl = '0;
      check("s0_payload", 64'(o0), 64'(e));
    end
  end

  initial begin
    // 1. reset and idle
    repeat (2) @(posedge clk);
    #3;
    check("rst_valid1", 64'(ov1), 64'd0);
    check("rst_ready1", 64'(ir1), 64'd1);
    check("rst_pay1", 64'(o1), 64'd0);
    check("rst_ready0", 64'(ir0), 64'd1);
    check("rst_pay0", 64'(o0), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (3) tick();
    check("idle_valid1", 64'(ov1), 64'd0);
    check("idle_ctrl1", 64'(o1.ctrl), 64'd0);

    // 2. streaming with out_ready high
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_p = mk(8'h07);
    in_p.r1 = 8'hA5;
    in_p.pc = 12'h123;
    in_p.ctrl = '0;
    in_p.ctrl[REGWR] = 1'b1;
    tick();
    check("str_valid", 64'(ov1), 64'd1);
    check("str_r1", 64'(o1.r1), 64'hA5);
    check("str_pc", 64'(o1.pc), 64'h123);
    check("str_ctrl", 64'(o1.ctrl), 64'h10);
    for (int i = 0; i < 5; i++) begin
      in_p = mk(8'(8'h20 + i));
      tick();
      check("str_ready", 64'(ir1), 64'd1);
      check("str_imm", 64'(o1.imm), 64'(8'h20 + i));
    end
    in_valid = 1'b0;
    tick();

    // 3. back-pressure into the skid entry
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_p = mk(8'h01);
    tick();
    in_p = mk(8'h02);
    tick();
    check("bp_full_ready", 64'(ir1), 64'd0);
    check("bp_hold_imm", 64'(o1.imm), 64'h01);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_second_imm", 64'(o1.imm), 64'h02);
    check("bp_ready_back", 64'(ir1), 64'd1);
    tick();
    check("bp_drained", 64'(ov1), 64'd0);

    // 4. flush in FULL with a simultaneous input
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_p = mk(8'h11);
    tick();
    in_p = mk(8'h22);
    tick();
    flush = 1'b1;
    in_p = mk(8'h33);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", 64'(ov1), 64'd0);
    check("fl_ctrl", 64'(o1.ctrl), 64'd0);
    check("fl_ready", 64'(ir1), 64'd1);
    out_ready = 1'b1;
    repeat (3) tick();

    // 5. pass-through ready on the single-entry variant
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_p = mk(8'h44);
    tick();
    in_valid = 1'b0;
    check("s0_stall_ready", 64'(ir0), 64'd0);
    out_ready = 1'b1;
    #1;
    check("s0_comb_ready", 64'(ir0), 64'd1);
    in_valid = 1'b1;
    in_p = mk(8'h55);
    tick();
    in_valid = 1'b0;
    check("s0_new_imm", 64'(o0.imm), 64'h55);
    repeat (3) tick();

    // 6. asynchronous reset while FULL
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_p = mk(8'h66);
    tick();
    in_p = mk(8'h77);
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("ar_valid", 64'(ov1), 64'd0);
    check("ar_ready", 64'(ir1), 64'd1);
    check("ar_imm", 64'(o1.imm), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_p = mk(8'h88);
    tick();
    in_valid = 1'b0;
    check("ar_first_valid", 64'(ov1), 64'd1);
    check("ar_first_imm", 64'(o1.imm), 64'h88);
    tick();

    // Mixed traffic with occasional flushes, checked by the model
    for (int i = 0; i < 80; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      in_p = mk(8'(8'h90 + i));
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_exe_pipe_stage.md
Name: id_exe_pipe_stage

Overview:
Parametrised ID->EXE pipeline stage register. It replaces the plain always-load register with a valid/ready handshaked stage. It adds stall back-pressure, synchronous flush (bubble insertion) and an optional 2-entry skid buffer, so that EXE back-pressure does not combinationally reach ID. It sits between the decode/register-read logic and the ALU/forwarding stage.

Parameters:
DATA_W, 8, width of register-file data, immediate and branch displacement
PC_W, 12, width of PC+1
RA_W, 3, register address width (rd/rs/rt)
ALUOP_W, 4, ALU opcode width
CTRL_W, 5, control-bit vector width; bit order {regWr, memRd, memWr, cWr, zWr}, MSB first
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with pass-through ready

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ID presents a valid instruction
in_ready  out  1  stage can accept this cycle
flush  in  1  synchronous kill of all held instructions (branch taken / hazard)
ctrl_in  in  CTRL_W  control bits
aluop_in  in  ALUOP_W  ALU opcode
rd_in, rs_in, rt_in  in  RA_W each  register addresses
imm_in, rdata1_in, rdata2_in, brdisp_in  in  DATA_W each  operands
pcp1_in  in  PC_W  PC+1
out_valid  out  1  EXE holds a valid instruction
out_ready  in  1  EXE consumes this cycle
ctrl_out, aluop_out, rd_out, rs_out, rt_out, imm_out, rdata1_out, rdata2_out, brdisp_out, pcp1_out  out  widths as inputs  registered payload

Behaviour:
- Reset (rst_n=0, asynchronous): all payload registers are 0, out_valid=0, skid entry empty. in_ready=1 while reset is asserted and after it is released.
- Accept = in_valid & in_ready. Deliver = out_valid & out_ready. Latency is 1 cycle from an accepted input to out_valid with that payload.
- ctrl_out is forced to 0 whenever out_valid=0, so a bubble never writes the register file, memory or flags. All other payload outputs hold their last value.
- SKID=1, states EMPTY/ONE/FULL (FULL = main and skid entries both valid):
  - EMPTY + accept -> ONE; input loads into main.
  - ONE + accept + deliver -> ONE; main reloads from input.
  - ONE + accept + no deliver -> FULL; input loads into skid.
  - ONE + deliver + no accept -> EMPTY.
  - FULL + deliver -> ONE; main loads from skid.
  - in_ready = ~skid_valid, driven from a register. It is never a combinational function of out_ready.
- SKID=0: single entry; in_ready = ~out_valid | out_ready (combinational). Accept loads main; deliver without accept clears out_valid.
- Flush has priority over everything in the same cycle. It clears out_valid and skid_valid and drops any simultaneous accept. The next state is EMPTY, and in_ready=1 in the following cycle. Payload data registers are not cleared.
- Order is always preserved (FIFO); no instruction is duplicated or lost without a flush.
- in_valid with in_ready=0: the stage takes no action. ID must hold its payload stable.

Decomposition:
- Shared package pipe_pkg: CTRL_W, the control-bit index constants (REGWR=4, MEMRD=3, MEMWR=2, CWR=1, ZWR=0), and default width constants.
- Sub-module pipe_skid_buf: a generic payload-width skid/handshake buffer with a SKID parameter and flush. id_exe_pipe_stage concatenates its fields into one vector, instantiates pipe_skid_buf, splits the output vector back into fields, and applies the ctrl bubble mask.

Test Plan:
1. Reset then idle: rst_n=0 mid-cycle -> all outputs 0 immediately, out_valid=0, in_ready=1; after release with in_valid=0 -> out_valid stays 0 and ctrl_out stays 0.
2. Streaming, SKID=1, out_ready=1: accept rdata1_in=8'hA5, pcp1_in=12'h123, ctrl_in=5'b10000 -> next cycle out_valid=1, rdata1_out=8'hA5, pcp1_out=12'h123, ctrl_out=5'b10000; then one instruction per cycle with in_ready held at 1.
3. Back-pressure: out_ready=0, send imm 8'h01 then 8'h02 -> state FULL, in_ready=0, imm_out=8'h01 held; raise out_ready -> delivers 8'h01, then 8'h02, in that order, with in_ready=1 one cycle after the first deliver.
4. Flush in FULL with a simultaneous in_valid=1 -> next cycle out_valid=0, ctrl_out=0, in_ready=1; the flushed instructions and the input from that cycle never appear on the outputs.
5. SKID=0 with out_ready=0 and out_valid=1 -> in_ready=0 in the same cycle; toggling out_ready to 1 -> in_ready=1 combinationally and the new payload is accepted.
6. Reset asserted in FULL -> out_valid=0 and skid cleared asynchronously; after release, in_ready=1 and the first new instruction emerges after 1 cycle.
